// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: producer/consumer requests plus status.
// The producer side uses master; the FIFO uses slave.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  // wr_en/rd_en are requests, not a valid/ready pair: a request is taken on
  // the rising edge only when the matching accept condition holds (write
  // needs room or a same-cycle pop, read needs a stored word). A request
  // that is not taken is dropped and flagged through overflow/underflow.
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of any depth with exact count, threshold and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // A pop in the same cycle frees a slot, so a full FIFO still takes a write.
  assign rd_acc = bus.rd_en & ~empty_c;
  assign wr_acc = bus.wr_en & (~full_c | rd_acc);

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[w_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_acc) begin
        w_ptr <= (w_ptr == LAST_PTR) ? '0 : w_ptr + 1'b1;
      end
      if (rd_acc) begin
        r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A fresh error in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (bus.wr_en & ~wr_acc) | (overflow_q & ~bus.err_clr);
      underflow_q <= (bus.rd_en & empty_c) | (underflow_q & ~bus.err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always on the output; rd_en acknowledges it.
  assign bus.data_out = mem[r_ptr];
`else
  logic [DATA_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (rd_acc) begin
      data_out_q <= mem[r_ptr];
    end
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a DEPTH=5 instance checked against a queue model every
// cycle, plus a DEPTH=16 instance on the same stimulus for the full-FIFO corner case.
module tb_sync_fifo_param;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] data_in = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(W), .DEPTH(5))  bus_a ();
  sync_fifo_param_if #(.DATA_WIDTH(W), .DEPTH(16)) bus_b ();

  assign bus_a.wr_en   = wr_en;
  assign bus_a.rd_en   = rd_en;
  assign bus_a.err_clr = err_clr;
  assign bus_a.data_in = data_in;
  assign bus_b.wr_en   = wr_en;
  assign bus_b.rd_en   = rd_en;
  assign bus_b.err_clr = err_clr;
  assign bus_b.data_in = data_in;

  sync_fifo_param #(.DATA_WIDTH(W), .DEPTH(5), .AFULL_THRESH(3), .AEMPTY_THRESH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  sync_fifo_param #(.DATA_WIDTH(W), .DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Reference model for dut_a: a queue of stored words plus the error flags.
  logic [W-1:0] exp_q[$];
  logic         m_ov;
  logic         m_un;
  logic [W-1:0] m_dout;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic clr, input logic [W-1:0] din);
    int  n;
    logic rd_ok, wr_ok;
    n     = exp_q.size();
    rd_ok = rd && (n > 0);
    wr_ok = wr && ((n < 5) || rd_ok);
    if (rd_ok) m_dout = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(din);
    m_ov = (wr && !wr_ok) || (m_ov && !clr);
    m_un = (rd && (n == 0)) || (m_un && !clr);
  endtask

  task automatic check_a();
    int n;
    n = exp_q.size();
    chk("a_count", int'(bus_a.count), n);
    chk("a_empty", int'(bus_a.empty), int'(n == 0));
    chk("a_full", int'(bus_a.full), int'(n == 5));
    chk("a_almost_full", int'(bus_a.almost_full), int'(n >= 3));
    chk("a_almost_empty", int'(bus_a.almost_empty), int'(n <= 2));
    chk("a_overflow", int'(bus_a.overflow), int'(m_ov));
    chk("a_underflow", int'(bus_a.underflow), int'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
    if (n > 0) chk("a_data_out", int'(bus_a.data_out), int'(exp_q[0]));
`else
    chk("a_data_out", int'(bus_a.data_out), int'(m_dout));
`endif
  endtask

  // Drive one cycle of requests, let the edge happen, then check dut_a.
  task automatic cycle(input logic wr, input logic rd, input logic clr, input logic [W-1:0] din);
    wr_en   = wr;
    rd_en   = rd;
    err_clr = clr;
    data_in = din;
    @(posedge clk);
    model_step(wr, rd, clr, din);
    #1;
    check_a();
  endtask

  // Assert reset mid-cycle, check outputs before any edge, release after one edge.
  task automatic do_reset();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    exp_q.delete();
    m_ov   = 1'b0;
    m_un   = 1'b0;
    m_dout = '0;
    #1;
    check_a();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic         wr, rd, clr;
    logic [W-1:0] din;
    int           cnt;
    logic         full, empty, af, ae, ov, un;
    logic [W-1:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic rd, input logic clr, input logic [W-1:0] din,
                              input int cnt, input logic full, input logic empty, input logic af,
                              input logic ae, input logic ov, input logic un, input logic [W-1:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae; v.ov = ov; v.un = un; v.dout = dout;
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    //              wr rd clr din    cnt full emp af ae ov un dout
    vecs[0]  = mk(1, 0, 0, 8'h11,  1, 0, 0, 0, 1, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 0, 8'h12,  2, 0, 0, 0, 1, 0, 0, 8'h00);
    vecs[2]  = mk(1, 0, 0, 8'h13,  3, 0, 0, 1, 0, 0, 0, 8'h00);
    vecs[3]  = mk(1, 0, 0, 8'h14,  4, 0, 0, 1, 0, 0, 0, 8'h00);
    vecs[4]  = mk(1, 0, 0, 8'h15,  5, 1, 0, 1, 0, 0, 0, 8'h00);
    vecs[5]  = mk(1, 0, 0, 8'h99,  5, 1, 0, 1, 0, 1, 0, 8'h00);
    vecs[6]  = mk(0, 1, 0, 8'h00,  4, 0, 0, 1, 0, 1, 0, 8'h11);
    vecs[7]  = mk(0, 1, 0, 8'h00,  3, 0, 0, 1, 0, 1, 0, 8'h12);
    vecs[8]  = mk(0, 1, 0, 8'h00,  2, 0, 0, 0, 1, 1, 0, 8'h13);
    vecs[9]  = mk(0, 1, 0, 8'h00,  1, 0, 0, 0, 1, 1, 0, 8'h14);
    vecs[10] = mk(0, 1, 0, 8'h00,  0, 0, 1, 0, 1, 1, 0, 8'h15);
    vecs[11] = mk(0, 0, 1, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h15);
    vecs[12] = mk(0, 1, 0, 8'h00,  0, 0, 1, 0, 1, 0, 1, 8'h15);
    vecs[13] = mk(0, 1, 1, 8'h00,  0, 0, 1, 0, 1, 0, 1, 8'h15);
    vecs[14] = mk(0, 0, 1, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h15);
    vecs[15] = mk(1, 1, 0, 8'h77,  1, 0, 0, 0, 1, 0, 1, 8'h15);
    vecs[16] = mk(0, 1, 1, 8'h00,  0, 0, 1, 0, 1, 0, 0, 8'h77);

    do_reset();

    // Fill/overflow/drain/underflow table on the DEPTH=5 instance.
    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      chk($sformatf("tbl%0d_count", i), int'(bus_a.count), vecs[i].cnt);
      chk($sformatf("tbl%0d_full", i), int'(bus_a.full), int'(vecs[i].full));
      chk($sformatf("tbl%0d_empty", i), int'(bus_a.empty), int'(vecs[i].empty));
      chk($sformatf("tbl%0d_afull", i), int'(bus_a.almost_full), int'(vecs[i].af));
      chk($sformatf("tbl%0d_aempty", i), int'(bus_a.almost_empty), int'(vecs[i].ae));
      chk($sformatf("tbl%0d_ovf", i), int'(bus_a.overflow), int'(vecs[i].ov));
      chk($sformatf("tbl%0d_unf", i), int'(bus_a.underflow), int'(vecs[i].un));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("tbl%0d_dout", i), int'(bus_a.data_out), int'(vecs[i].dout));
`endif
    end

    // Interleaved write/read pairs walk both pointers around the 5-entry ring twice.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 1'b0, W'(i));
      chk("wrap_count_after_wr", int'(bus_a.count), 1);
`ifdef SYNC_FIFO_FWFT_EN
      chk("wrap_fwft_head", int'(bus_a.data_out), i);
`endif
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
      chk("wrap_dout", int'(bus_a.data_out), i);
`endif
      chk("wrap_empty", int'(bus_a.empty), 1);
    end

    // Full DEPTH=16 instance with simultaneous write and read for 4 cycles.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, W'(8'h40 + i));
    chk("b_full_count", int'(bus_b.count), 16);
    chk("b_full_flag", int'(bus_b.full), 1);
    chk("b_full_afull", int'(bus_b.almost_full), 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, W'(8'h80 + i));
      chk("b_rw_count", int'(bus_b.count), 16);
      chk("b_rw_overflow", int'(bus_b.overflow), 0);
`ifdef SYNC_FIFO_FWFT_EN
      chk("b_rw_dout", int'(bus_b.data_out), 8'h41 + i);
`else
      chk("b_rw_dout", int'(bus_b.data_out), 8'h40 + i);
`endif
    end

    // Reset dropped mid-cycle with words stored.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h21);
    cycle(1'b1, 1'b0, 1'b0, 8'h22);
    cycle(1'b1, 1'b1, 1'b0, 8'h23);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_count", int'(bus_a.count), 0);
    chk("rst_mid_empty", int'(bus_a.empty), 1);
    chk("rst_mid_full", int'(bus_a.full), 0);
    chk("rst_mid_b_count", int'(bus_b.count), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_mid_dout", int'(bus_a.data_out), 0);
`endif
    do_reset();

    // Single word into an empty FIFO, then popped.
    cycle(1'b1, 1'b0, 1'b0, 8'hA5);
    chk("one_word_empty", int'(bus_a.empty), 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_show", int'(bus_a.data_out), 8'hA5);
`else
    chk("std_hold", int'(bus_a.data_out), 8'h00);
`endif
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("one_word_pop_empty", int'(bus_a.empty), 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("std_read", int'(bus_a.data_out), 8'hA5);
`endif

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 99) < 50),
            logic'($urandom_range(0, 99) < 8), W'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
